// File: rtl/layer_controller.sv
// Sequences one fully-connected layer: broadcasts inputs to all neurons, gathers their outputs,
// then streams them out. Optional COLLECT watchdog enabled by LAYER_CTRL_TIMEOUT_EN.
module layer_controller #(
  parameter int unsigned NUM_NEURON     = 4,
  parameter int unsigned NUM_WEIGHT     = 8,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                             i_clk,
  input  logic                             i_reset,
  input  logic [DATA_WIDTH-1:0]            i_data,
  input  logic                             i_data_valid,
  output logic                             o_data_ready,
  output logic [DATA_WIDTH-1:0]            o_neuron_input,
  output logic                             o_neuron_input_valid,
  input  logic [NUM_NEURON-1:0]            i_neuron_input_ready,
  input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_neuron_output,
  input  logic [NUM_NEURON-1:0]            i_neuron_output_valid,
  output logic [DATA_WIDTH-1:0]            o_data,
  output logic                             o_data_valid,
  input  logic                             i_data_ready,
  output logic                             o_busy,
  output logic                             o_error
);

  localparam int unsigned IdxW = (NUM_NEURON > 1) ? $clog2(NUM_NEURON) : 1;
  localparam int unsigned CntW = (NUM_WEIGHT > 1) ? $clog2(NUM_WEIGHT) : 1;
  localparam logic [CntW-1:0] LastIn  = CntW'(NUM_WEIGHT - 1);
  localparam logic [IdxW-1:0] LastIdx = IdxW'(NUM_NEURON - 1);

  localparam logic [1:0] StFeed    = 2'd0;
  localparam logic [1:0] StCollect = 2'd1;
  localparam logic [1:0] StDrain   = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       in_cnt_q, in_cnt_d;
  logic [NUM_NEURON-1:0] captured_q, captured_d;
  logic [DATA_WIDTH-1:0] res_q [NUM_NEURON];
  logic [DATA_WIDTH-1:0] res_d [NUM_NEURON];
  logic [IdxW-1:0]       out_idx_q, out_idx_d, nxt_idx;
  logic [DATA_WIDTH-1:0] nin_q, nin_d;
  logic                  nin_valid_q, nin_valid_d;
  logic [DATA_WIDTH-1:0] odata_q, odata_d;
  logic                  odata_valid_q, odata_valid_d;
  logic                  error_q, error_d;
  logic                  data_ready;

`ifdef LAYER_CTRL_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TmoW-1:0] LastTmo = TmoW'(TIMEOUT_CYCLES - 1);
  logic [TmoW-1:0] tmo_q, tmo_d;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Gated by reset so every output reads 0 while reset is held.
  assign data_ready = !i_reset && (state_q == StFeed) && (&i_neuron_input_ready) && !nin_valid_q;
  assign nxt_idx    = out_idx_q + IdxW'(1);

  always_comb begin
    state_d       = state_q;
    in_cnt_d      = in_cnt_q;
    captured_d    = captured_q;
    res_d         = res_q;
    out_idx_d     = out_idx_q;
    nin_d         = nin_q;
    nin_valid_d   = 1'b0;
    odata_d       = odata_q;
    odata_valid_d = odata_valid_q;
    error_d       = error_q;
`ifdef LAYER_CTRL_TIMEOUT_EN
    tmo_d         = tmo_q;
`endif
    case (state_q)
      StFeed: begin
        if (|i_neuron_output_valid) error_d = 1'b1;
        if (i_data_valid && data_ready) begin
          nin_d       = i_data;
          nin_valid_d = 1'b1;
          if (in_cnt_q == LastIn) begin
            in_cnt_d = '0;
            state_d  = StCollect;
`ifdef LAYER_CTRL_TIMEOUT_EN
            tmo_d    = '0;
`endif
          end else begin
            in_cnt_d = in_cnt_q + CntW'(1);
          end
        end
      end
      StCollect: begin
        for (int n = 0; n < NUM_NEURON; n++) begin
          if (i_neuron_output_valid[n]) begin
            if (captured_q[n]) begin
              error_d = 1'b1;
            end else begin
              res_d[n]      = i_neuron_output[n*DATA_WIDTH +: DATA_WIDTH];
              captured_d[n] = 1'b1;
            end
          end
        end
        if (&captured_q) begin
          state_d       = StDrain;
          captured_d    = '0;
          out_idx_d     = '0;
          odata_valid_d = 1'b1;
          odata_d       = res_q[0];
`ifdef LAYER_CTRL_TIMEOUT_EN
        end else if (tmo_q == LastTmo) begin
          // Give up on silent neurons: their slots drain as zero.
          for (int n = 0; n < NUM_NEURON; n++) begin
            if (!captured_d[n]) res_d[n] = '0;
          end
          error_d       = 1'b1;
          state_d       = StDrain;
          captured_d    = '0;
          out_idx_d     = '0;
          odata_valid_d = 1'b1;
          odata_d       = res_d[0];
        end else begin
          tmo_d = tmo_q + TmoW'(1);
`endif
        end
      end
      StDrain: begin
        if (|i_neuron_output_valid) error_d = 1'b1;
        if (odata_valid_q && i_data_ready) begin
          if (out_idx_q == LastIdx) begin
            odata_valid_d = 1'b0;
            out_idx_d     = '0;
            state_d       = StFeed;
          end else begin
            out_idx_d = nxt_idx;
            odata_d   = res_q[nxt_idx];
          end
        end
      end
      default: state_d = StFeed;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q       <= StFeed;
      in_cnt_q      <= '0;
      captured_q    <= '0;
      out_idx_q     <= '0;
      nin_q         <= '0;
      nin_valid_q   <= 1'b0;
      odata_q       <= '0;
      odata_valid_q <= 1'b0;
      error_q       <= 1'b0;
      for (int n = 0; n < NUM_NEURON; n++) res_q[n] <= '0;
`ifdef LAYER_CTRL_TIMEOUT_EN
      tmo_q         <= '0;
`endif
    end else begin
      state_q       <= state_d;
      in_cnt_q      <= in_cnt_d;
      captured_q    <= captured_d;
      out_idx_q     <= out_idx_d;
      nin_q         <= nin_d;
      nin_valid_q   <= nin_valid_d;
      odata_q       <= odata_d;
      odata_valid_q <= odata_valid_d;
      error_q       <= error_d;
      res_q         <= res_d;
`ifdef LAYER_CTRL_TIMEOUT_EN
      tmo_q         <= tmo_d;
`endif
    end
  end

  assign o_data_ready         = data_ready;
  assign o_neuron_input       = nin_q;
  assign o_neuron_input_valid = nin_valid_q;
  assign o_data               = odata_q;
  assign o_data_valid         = odata_valid_q;
  assign o_busy               = (state_q != StFeed);
  assign o_error              = error_q;

endmodule

// File: tb/tb_layer_controller.sv
// Scoreboard bench for layer_controller: broadcast words and drained results are queued as
// they are driven and compared when the DUT presents them.
module tb_layer_controller;

  logic        clk = 1'b0;
  logic        i_reset;
  logic [15:0] i_data;
  logic        i_data_valid;
  logic        o_data_ready;
  logic [15:0] o_neuron_input;
  logic        o_neuron_input_valid;
  logic [3:0]  nrdy;
  logic [63:0] nout;
  logic [3:0]  noutv;
  logic [15:0] o_data;
  logic        o_data_valid;
  logic        i_data_ready;
  logic        o_busy;
  logic        o_error;

  layer_controller #(
    .NUM_NEURON    (4),
    .NUM_WEIGHT    (8),
    .DATA_WIDTH    (16),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .i_clk                (clk),
    .i_reset              (i_reset),
    .i_data               (i_data),
    .i_data_valid         (i_data_valid),
    .o_data_ready         (o_data_ready),
    .o_neuron_input       (o_neuron_input),
    .o_neuron_input_valid (o_neuron_input_valid),
    .i_neuron_input_ready (nrdy),
    .i_neuron_output      (nout),
    .i_neuron_output_valid(noutv),
    .o_data               (o_data),
    .o_data_valid         (o_data_valid),
    .i_data_ready         (i_data_ready),
    .o_busy               (o_busy),
    .o_error              (o_error)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned stall_from = 0, stall_to = 0;
  int unsigned n_strobe = 0, last_strobe = 0, n_hs = 0, last_hs = 0;
  int unsigned drain_cyc = 0, busy_cyc = 0;
  logic        rdy_toggle = 1'b0;
  logic        prev_stall = 1'b0, prev_valid = 1'b0, prev_busy = 1'b0, accepted = 1'b0;
  logic [15:0] exp_in[$];
  logic [15:0] exp_out[$];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // One clock: monitor at the falling edge, then advance and drive the per-cycle inputs.
  task automatic tick();
    @(negedge clk);
    if (!i_reset) begin
      if (!(&nrdy)) check_eq("stall_ready", {31'd0, o_data_ready}, 32'd0);
      if (prev_stall) check_eq("stall_strobe", {31'd0, o_neuron_input_valid}, 32'd0);
      if (o_neuron_input_valid) begin
        if (exp_in.size() == 0) check_eq("strobe_extra", 32'd1, 32'd0);
        else check_eq("strobe", {16'd0, o_neuron_input}, {16'd0, exp_in.pop_front()});
        n_strobe++;
        last_strobe = cyc;
      end
      if (o_data_valid) begin
        if (!prev_valid) drain_cyc = cyc;
        if (exp_out.size() == 0) check_eq("drain_extra", 32'd1, 32'd0);
        else begin
          check_eq("drain", {16'd0, o_data}, {16'd0, exp_out[0]});
          if (i_data_ready) begin
            void'(exp_out.pop_front());
            n_hs++;
            last_hs = cyc;
          end
        end
      end
      if (o_busy && !prev_busy) busy_cyc = cyc;
    end
    prev_stall = !(&nrdy);
    prev_valid = o_data_valid;
    prev_busy  = o_busy;
    accepted   = i_data_valid && o_data_ready;
    @(posedge clk);
    cyc++;
    #1;
    nrdy = (cyc >= stall_from && cyc < stall_to) ? 4'b1011 : 4'b1111;
    if (rdy_toggle) i_data_ready = ~i_data_ready;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_dready"}, {31'd0, o_data_ready}, 32'd0);
    check_eq({tag, "_nin"}, {16'd0, o_neuron_input}, 32'd0);
    check_eq({tag, "_ninv"}, {31'd0, o_neuron_input_valid}, 32'd0);
    check_eq({tag, "_odata"}, {16'd0, o_data}, 32'd0);
    check_eq({tag, "_ovalid"}, {31'd0, o_data_valid}, 32'd0);
    check_eq({tag, "_busy"}, {31'd0, o_busy}, 32'd0);
    check_eq({tag, "_error"}, {31'd0, o_error}, 32'd0);
  endtask

  task automatic do_reset();
    i_reset = 1'b1;
    @(posedge clk);
    #1;
    check_outputs_zero("reset");
    tick();
    i_reset = 1'b0;
    exp_in.delete();
    exp_out.delete();
    tick();
  endtask

  task automatic feed(input int unsigned base, input int pulse_k);
    for (int k = 0; k < 8; k++) begin
      i_data       = 16'(base + k);
      i_data_valid = 1'b1;
      exp_in.push_back(16'(base + k));
      if (k == pulse_k) begin
        nout[47:32] = 16'hDEAD;
        noutv       = 4'b0100;
      end
      accepted = 1'b0;
      for (int t = 0; t < 40 && !accepted; t++) begin
        tick();
        noutv = '0;
      end
      if (!accepted) check_eq("feed_timeout", 32'd0, 32'd1);
    end
    i_data_valid = 1'b0;
    tick();
    check_eq("feed_all_strobed", exp_in.size(), 32'd0);
  endtask

  task automatic pulse(input int idx, input logic [15:0] val);
    nout[idx*16 +: 16] = val;
    noutv              = 4'(1 << idx);
    tick();
    noutv              = '0;
  endtask

  task automatic wait_idle();
    for (int t = 0; t < 100 && (exp_out.size() != 0 || o_busy); t++) tick();
    check_eq("idle_busy", {31'd0, o_busy}, 32'd0);
    check_eq("idle_queue", exp_out.size(), 32'd0);
  endtask

  int unsigned s0, st0, hs0;

  initial begin
    i_reset = 1'b1; i_data = '0; i_data_valid = 1'b0; nrdy = 4'hF;
    nout = '0; noutv = '0; i_data_ready = 1'b0;
    do_reset();

    // Basic feed: eight strobes, two cycles apart.
    check_eq("idle_busy0", {31'd0, o_busy}, 32'd0);
    s0 = cyc; st0 = n_strobe;
    feed(1, -1);
    check_eq("strobe_count", n_strobe - st0, 32'd8);
    check_eq("strobe_last_cyc", last_strobe - s0, 32'd15);
    tick();
    check_eq("nin_hold", {16'd0, o_neuron_input}, 32'h8);
    check_eq("collect_busy", {31'd0, o_busy}, 32'd1);
    check_eq("collect_dready", {31'd0, o_data_ready}, 32'd0);

    // Collect on separate cycles, drain with ready held high.
    i_data_ready = 1'b1;
    hs0 = n_hs;
    for (int n = 0; n < 4; n++) exp_out.push_back(16'(16'h10 * (n + 1)));
    for (int n = 0; n < 4; n++) pulse(n, 16'(16'h10 * (n + 1)));
    wait_idle();
    check_eq("drain_count", n_hs - hs0, 32'd4);
    check_eq("drain_consec", last_hs - drain_cyc, 32'd3);
    check_eq("feed_ready_back", {31'd0, o_data_ready}, 32'd1);

    // Input-ready stall mid-feed.
    stall_from = cyc + 5; stall_to = cyc + 10; st0 = n_strobe;
    feed(16'h20, -1);
    check_eq("stall_strobe_count", n_strobe - st0, 32'd8);
    for (int n = 0; n < 4; n++) exp_out.push_back(16'(16'h100 + n));
    for (int n = 0; n < 4; n++) pulse(n, 16'(16'h100 + n));
    wait_idle();

    // Downstream ready toggling each cycle.
    feed(16'h30, -1);
    i_data_ready = 1'b0;
    hs0 = n_hs;
    for (int n = 0; n < 4; n++) exp_out.push_back(16'(16'h200 + 3 * n));
    for (int n = 0; n < 4; n++) pulse(n, 16'(16'h200 + 3 * n));
    rdy_toggle = 1'b1;
    wait_idle();
    rdy_toggle = 1'b0;
    check_eq("toggle_count", n_hs - hs0, 32'd4);
    check_eq("toggle_no_error", {31'd0, o_error}, 32'd0);

    // Protocol errors: stray valid in FEED, repeat valid in COLLECT.
    i_data_ready = 1'b1;
    feed(16'h40, 3);
    check_eq("err_feed", {31'd0, o_error}, 32'd1);
    exp_out.push_back(16'h00A0); exp_out.push_back(16'h0011);
    exp_out.push_back(16'h00A2); exp_out.push_back(16'h00A3);
    pulse(1, 16'h0011);
    pulse(1, 16'h0099);
    pulse(0, 16'h00A0);
    pulse(2, 16'h00A2);
    pulse(3, 16'h00A3);
    wait_idle();
    check_eq("err_sticky", {31'd0, o_error}, 32'd1);

`ifdef LAYER_CTRL_TIMEOUT_EN
    do_reset();
    i_data_ready = 1'b0;
    feed(16'h50, -1);
    exp_out.push_back(16'h0B0); exp_out.push_back(16'h0B1);
    exp_out.push_back(16'h0B2); exp_out.push_back(16'h000);
    for (int n = 0; n < 3; n++) pulse(n, 16'(16'h0B0 + n));
    for (int t = 0; t < 40 && !o_data_valid; t++) tick();
    tick();
    check_eq("tmo_drain_delay", drain_cyc - busy_cyc, 32'd16);
    check_eq("tmo_error", {31'd0, o_error}, 32'd1);
    i_data_ready = 1'b1;
    for (int t = 0; t < 20 && exp_out.size() > 1; t++) tick();
    i_data_ready = 1'b0;
    tick();
    check_eq("tmo_w4_valid", {31'd0, o_data_valid}, 32'd1);
    check_eq("tmo_w4_data", {16'd0, o_data}, 32'd0);
    i_reset = 1'b1;
    #1;
    check_outputs_zero("midreset");
    exp_out.delete();
    tick();
    i_reset = 1'b0;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/layer_controller.md
Name: layer_controller

Overview:
- Sequences one fully-connected layer of `neuron` instances.
- Broadcasts NUM_WEIGHT upstream input words to all NUM_NEURON neurons, gated by every neuron's input-ready.
- Collects each neuron's output into an internal buffer, then streams the results downstream serially with valid/ready.
- Sits between two layers, or between the input stream and layer 1.

Parameters:
- NUM_NEURON, 4, neurons in the layer; 1..64.
- NUM_WEIGHT, 8, inputs per inference (= weights per neuron); ≥1.
- DATA_WIDTH, 16, width of each data word.
- TIMEOUT_CYCLES, 1024, COLLECT watchdog limit; used only with LAYER_CTRL_TIMEOUT_EN.

Ports:
- i_clk  in  1  clock, rising edge.
- i_reset  in  1  asynchronous, active-high reset.
- i_data  in  DATA_WIDTH  upstream input word.
- i_data_valid  in  1  upstream word valid.
- o_data_ready  out  1  controller accepts upstream word this cycle.
- o_neuron_input  out  DATA_WIDTH  word broadcast to all neurons' i_input.
- o_neuron_input_valid  out  1  broadcast strobe to all neurons' i_input_valid.
- i_neuron_input_ready  in  NUM_NEURON  bit n = neuron n o_input_ready.
- i_neuron_output  in  NUM_NEURON*DATA_WIDTH  neuron n output at bits [n*DATA_WIDTH +: DATA_WIDTH].
- i_neuron_output_valid  in  NUM_NEURON  bit n = neuron n o_output_valid.
- o_data  out  DATA_WIDTH  downstream result word.
- o_data_valid  out  1  downstream word valid.
- i_data_ready  in  1  downstream accepts word.
- o_busy  out  1  high in COLLECT or DRAIN.
- o_error  out  1  sticky protocol-error flag.

Behaviour:
- Reset: async assert, sync release. State FEED; counters 0; captured mask 0; buffer 0. All outputs 0: o_data_ready, o_neuron_input, o_neuron_input_valid, o_data, o_data_valid, o_busy, o_error.
- FEED state:
  - o_data_ready = (&i_neuron_input_ready) && !o_neuron_input_valid.
  - Transfer when i_data_valid && o_data_ready.
  - On a transfer: next cycle o_neuron_input = i_data and o_neuron_input_valid = 1 for exactly one cycle (1-cycle latency).
  - The back-to-back limit is therefore one word per 2 cycles.
  - o_neuron_input holds its value after the strobe drops.
  - in_cnt increments per transfer. The transfer that makes in_cnt reach NUM_WEIGHT resets in_cnt to 0 and moves to COLLECT.
  - Any i_neuron_output_valid bit high in FEED sets o_error; that output is discarded.
- COLLECT state:
  - o_data_ready = 0.
  - For each n with i_neuron_output_valid[n] and captured[n] = 0: store the word in buf[n] and set captured[n].
  - Repeat valid for an already-captured neuron is ignored; first value kept; o_error set.
  - Multiple neurons may capture in the same cycle.
  - Once the captured mask is all-ones (registered), the next cycle enters DRAIN with out_idx = 0 and the mask cleared.
- DRAIN state:
  - o_data_valid = 1, o_data = buf[out_idx]; both registered and stable while i_data_ready = 0.
  - On handshake: out_idx increments.
  - On the handshake with out_idx = NUM_NEURON-1: o_data_valid drops next cycle, state returns to FEED, out_idx = 0.
  - In DRAIN, o_data_ready = 0 (upstream stalls).
  - Neuron valids in DRAIN set o_error and are discarded.
- o_busy = (state != FEED).
- o_error clears only on reset.
- A reset mid-inference aborts immediately; the partial input count and buffer are discarded.

Optional Feature:
- Macro LAYER_CTRL_TIMEOUT_EN.
- Defined:
  - A cycle counter runs in COLLECT, cleared on entry.
  - If it reaches TIMEOUT_CYCLES with the mask incomplete: uncaptured buf entries are forced to 0, o_error is set, and the state moves to DRAIN.
- Undefined: no counter; COLLECT waits indefinitely.

Test Plan:
- Defaults; feed words 1..8 with i_data_valid held high and all input-ready bits high.
  - Required: 8 single-cycle broadcast strobes, 2 cycles apart, o_neuron_input = 1..8, then COLLECT.
- Neuron outputs 0x0010/0x0020/0x0030/0x0040 arrive on separate cycles, then i_data_ready = 1 constantly.
  - Required: o_data sequence 0x0010, 0x0020, 0x0030, 0x0040 on 4 consecutive cycles, then back in FEED with o_busy = 0.
- Hold i_neuron_input_ready = 4'b1011 for 5 cycles mid-feed.
  - Required: o_data_ready = 0 and no strobe during the stall; the input count resumes correctly; exactly 8 strobes total.
- In DRAIN, toggle i_data_ready 0/1 each cycle.
  - Required: o_data is stable while not ready; no word lost or duplicated; o_error stays 0.
- Pulse i_neuron_output_valid[2] during FEED, and neuron 1 valid twice in COLLECT (0x0011, then 0x0099).
  - Required: o_error = 1; buf[1] = 0x0011 drained.
- With LAYER_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES = 16, neuron 3 never valid.
  - Required: DRAIN entered 16 cycles after COLLECT entry; 4th word 0x0000; o_error = 1.
  - Also: assert i_reset mid-DRAIN; all outputs are 0 immediately.
